// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register word offsets, STATUS bit positions, transmit FSM state
// encoding, and a helper that packs the STATUS byte.
// Ports: none (package).
package uart_tx_mmio_pkg;

   // Word offsets, decoded from mem_addr[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   // STATUS bit positions. A STATUS write with the OVF bit set clears OVF.
   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_OVF       = 3;
   localparam int STAT_COUNT_LSB = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   function automatic logic [7:0] status_byte(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [3:0] count);
      logic [7:0] s;
      s                       = '0;
      s[STAT_BUSY]            = busy;
      s[STAT_FULL]            = full;
      s[STAT_EMPTY]           = empty;
      s[STAT_OVF]             = ovf;
      s[STAT_COUNT_LSB +: 4]  = count;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO holding bytes waiting to be transmitted.
// Ports:
//   clk, resetn           - clock, synchronous active-low reset
//   push, push_data       - write one entry (ignored when full)
//   pop, pop_data         - pop_data shows the head combinationally; pop
//                           advances it (ignored when empty)
//   full, empty, count    - occupancy, count is $clog2(DEPTH)+1 bits wide
module uart_tx_mmio_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count_reg == FULL_COUNT);
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   // The transmitter loads the head in the same cycle it pops, so the head
   // is read without a register stage.
   assign pop_data = mem[rd_ptr_reg];

   // Storage carries no reset; stale contents are unreachable once pointers reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter (8N1) with a small TX FIFO.
// Register window: 16 bytes at BASE_ADDR. Word 0 = DATA (write-only, byte 0
// is queued), word 1 = STATUS (BUSY, FULL, EMPTY, OVF, count[7:4]).
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   mem_addr     - byte address from the processor
//   mem_wdata    - write data
//   mem_wmask    - byte write enables, any bit set means write
//   mem_rstrb    - read strobe
//   mem_rdata    - registered read data, zero when the access missed the window
//   tx           - serial output, idle high
module uart_tx_mmio #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] BASE_ADDR    = 'h400000,
   parameter int              CLKS_PER_BIT = 104,
   parameter int              FIFO_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic [3:0]      mem_wmask,
   input  logic            mem_rstrb,
   output logic [XLEN-1:0] mem_rdata,
   output logic            tx
);

   import uart_tx_mmio_pkg::*;

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   // Bus decode
   logic sel, wr_en, data_wr, status_wr, push_req, overflow;
   // FIFO interface
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_head;
   logic [CNT_W-1:0] fifo_count;
   // Transmitter state
   tx_state_t        state_reg;
   logic [BAUD_W-1:0] baud_reg;
   logic [2:0]       bit_idx_reg;
   logic [7:0]       shift_reg;
   logic             tx_reg;
   logic             ovf_reg;
   logic [XLEN-1:0]  rdata_reg;
   logic [XLEN-1:0]  status_word;
   logic             baud_done;
   logic             unused_bits;

   assign sel       = (mem_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
   assign wr_en     = sel && (mem_wmask != 4'd0);
   assign data_wr   = wr_en && (mem_addr[3:2] == REG_DATA) && mem_wmask[0];
   assign status_wr = wr_en && (mem_addr[3:2] == REG_STATUS);
   // Fullness is judged before any same-cycle pop, so a write to a full FIFO
   // is always dropped.
   assign push_req  = data_wr && !fifo_full;
   assign overflow  = data_wr && fifo_full;

   assign baud_done = (baud_reg == BAUD_LAST);
   // Load a new byte from IDLE, or at the end of STOP so frames abut.
   assign fifo_pop  = !fifo_empty &&
                      ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_done));

   uart_tx_mmio_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push_req),
      .push_data (mem_wdata[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg   <= ST_IDLE;
         baud_reg    <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  shift_reg <= fifo_head;
                  baud_reg  <= '0;
                  tx_reg    <= 1'b0;
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud_reg    <= '0;
                  bit_idx_reg <= '0;
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= {1'b0, shift_reg[7:1]};
                  state_reg   <= ST_DATA;
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (bit_idx_reg == 3'd7) begin
                     tx_reg    <= 1'b1;
                     state_reg <= ST_STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= {1'b0, shift_reg[7:1]};
                  end
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (!fifo_empty) begin
                     shift_reg <= fifo_head;
                     tx_reg    <= 1'b0;
                     state_reg <= ST_START;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign status_word = {{(XLEN-8){1'b0}},
                         status_byte(state_reg != ST_IDLE, fifo_full, fifo_empty,
                                     ovf_reg, 4'(fifo_count))};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ovf_reg   <= 1'b0;
         rdata_reg <= '0;
      end else begin
         // A dropped byte outranks a clear in the same cycle.
         if (overflow) begin
            ovf_reg <= 1'b1;
         end else if (status_wr && mem_wdata[STAT_OVF]) begin
            ovf_reg <= 1'b0;
         end
         // Held between strobes; a strobe outside the window reads zero.
         if (mem_rstrb) begin
            rdata_reg <= (sel && (mem_addr[3:2] == REG_STATUS)) ? status_word : '0;
         end
      end
   end

   assign mem_rdata = rdata_reg;
   assign tx        = tx_reg;

   // Address byte offset and upper write-data bytes carry no meaning here.
   assign unused_bits = ^{mem_addr[1:0], mem_wdata[XLEN-1:8]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps
module tb_uart_tx_mmio;

   localparam int          XLEN  = 32;
   localparam logic [31:0] BASE  = 32'h0040_0000;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam int          FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wmask = '0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic        tx;

   uart_tx_mmio #(
      .XLEN(XLEN), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .tx(tx)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; samples at negedge see state after edge cyc
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Reference model: each accepted byte has a push edge and a frame start edge.
   int         p_q[$];
   int         s_q[$];
   logic [7:0] b_q[$];
   bit         ovf_m = 1'b0;

   function automatic int count_at(int c);
      int n = 0;
      foreach (p_q[i]) begin
         if (p_q[i] <= c) n++;
         if (s_q[i] <= c) n--;
      end
      return n;
   endfunction

   function automatic int frame_at(int c);
      foreach (s_q[i])
         if (c >= s_q[i] && c < s_q[i] + FRAME) return i;
      return -1;
   endfunction

   function automatic logic exp_tx(int c);
      int f = frame_at(c);
      int bitn;
      if (f < 0) return 1'b1;
      bitn = (c - s_q[f]) / CPB;
      if (bitn == 0) return 1'b0;
      if (bitn == 9) return 1'b1;
      return b_q[f][bitn-1];
   endfunction

   function automatic logic [31:0] status_exp(int c);
      logic [31:0] r = '0;
      int n = count_at(c);
      r[0]   = (frame_at(c) >= 0);
      r[1]   = (n == DEPTH);
      r[2]   = (n == 0);
      r[3]   = ovf_m;
      r[7:4] = 4'(n);
      return r;
   endfunction

   // Write driven during cycle k is captured at edge k+1; transmission of an
   // accepted byte begins one edge later, or when the previous frame ends.
   function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] m, int k);
      int e = k + 1;
      int s;
      if (a[31:4] != BASE[31:4] || m == 4'd0) return;
      if (a[3:2] == 2'd0 && m[0]) begin
         if (count_at(e - 1) < DEPTH) begin
            s = e + 1;
            if (s_q.size() > 0 && s_q[$] + FRAME > s) s = s_q[$] + FRAME;
            p_q.push_back(e);
            s_q.push_back(s);
            b_q.push_back(d[7:0]);
         end else begin
            ovf_m = 1'b1;
         end
      end else if (a[3:2] == 2'd1 && d[3]) begin
         ovf_m = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      p_q.delete();
      s_q.delete();
      b_q.delete();
      ovf_m = 1'b0;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   // Line monitor: tx compared to the model on every cycle while enabled.
   always @(negedge clk) begin
      if (check_en) begin
         checks++;
         if (tx !== exp_tx(cyc)) begin
            errors++;
            $display("FAIL tx_line: got %b, expected %b (cyc %0d)", tx, exp_tx(cyc), cyc);
         end
      end
   end

   // Bus tasks start just after a falling edge and return one cycle later.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      $display("cyc %0d WR addr=%h data=%h mask=%h", cyc, a, d, m);
      mem_addr  = a;
      mem_wdata = d;
      mem_wmask = m;
      model_write(a, d, m, cyc);
      @(negedge clk);
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic [31:0] ex);
      mem_addr  = a;
      mem_rstrb = 1'b1;
      ex = (a[31:4] == BASE[31:4] && a[3:2] == 2'd1) ? status_exp(cyc) : 32'd0;
      @(negedge clk);
      mem_rstrb = 1'b0;
      mem_addr  = '0;
      rd = mem_rdata;
      $display("cyc %0d RD addr=%h data=%h", cyc, a, rd);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_idle();
      int t = (s_q.size() > 0) ? s_q[$] + FRAME : cyc;
      wait_until(t + 1);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, ex, a;
      logic [39:0] got40, exp40;
      logic [9:0]  pat;
      int          k0;
      string       nm;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_tx", 64'(tx), 64'd1);
      check("reset_rdata", 64'(mem_rdata), 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      check_en = 1'b1;

      // Register map while idle
      vecs[0]  = '{1'b0, BASE + 32'h4,  32'h0,  4'h0, 32'h4};
      vecs[1]  = '{1'b0, BASE + 32'h0,  32'h0,  4'h0, 32'h0};
      vecs[2]  = '{1'b0, BASE + 32'h8,  32'h0,  4'h0, 32'h0};
      vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,  4'h0, 32'h0};
      vecs[4]  = '{1'b0, BASE + 32'h4,  32'h0,  4'h0, 32'h4};
      vecs[5]  = '{1'b0, BASE + 32'h14, 32'h0,  4'h0, 32'h0};
      vecs[6]  = '{1'b1, BASE + 32'h8,  32'hFF, 4'hF, 32'h0};
      vecs[7]  = '{1'b0, BASE + 32'h4,  32'h0,  4'h0, 32'h4};
      vecs[8]  = '{1'b1, BASE + 32'h10, 32'h55, 4'hF, 32'h0};
      vecs[9]  = '{1'b0, BASE + 32'h4,  32'h0,  4'h0, 32'h4};
      vecs[10] = '{1'b1, BASE + 32'h4,  32'h8,  4'hF, 32'h0};
      vecs[11] = '{1'b0, BASE + 32'h4,  32'h0,  4'h0, 32'h4};
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
         end else begin
            bus_read(vecs[i].addr, rd, ex);
            nm = $sformatf("vec%0d_rdata", i);
            check(nm, 64'(rd), 64'(vecs[i].exp));
         end
      end
      @(negedge clk);
      check("rdata_hold", 64'(mem_rdata), 64'h4);

      // Single byte frame, exact waveform
      k0 = cyc;
      bus_write(BASE, 32'hA5, 4'h1);
      check("a5_no_early_start", 64'(tx), 64'd1);
      pat = 10'b1101001010;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         got40[i] = tx;
         exp40[i] = pat[i / CPB];
      end
      check("a5_waveform", 64'(got40), 64'(exp40));
      repeat (2) @(negedge clk);
      bus_read(BASE + 32'h4, rd, ex);
      check("a5_idle_status", 64'(rd), 64'h4);

      // Back-to-back frames
      k0 = cyc;
      bus_write(BASE, 32'h01, 4'hF);
      bus_write(BASE, 32'h02, 4'hF);
      bus_write(BASE, 32'h03, 4'hF);
      wait_until(k0 + 1 + FRAME);
      check("b2b_stop1", 64'(tx), 64'd1);
      wait_until(k0 + 2 + FRAME);
      check("b2b_frame2_start", 64'(tx), 64'd0);
      wait_until(k0 + 2 + 2 * FRAME);
      check("b2b_frame3_start", 64'(tx), 64'd0);
      wait_until(k0 + 3 + 3 * FRAME);
      bus_read(BASE + 32'h4, rd, ex);
      check("b2b_end_status", 64'(rd), 64'h4);

      // Overflow: six writes, five fit
      for (int i = 0; i < 6; i++) bus_write(BASE, 32'h11 + i, 4'h1);
      bus_read(BASE + 32'h4, rd, ex);
      check("ovf_status_model", 64'(rd), 64'(ex));
      check("ovf_bit_set", 64'(rd[3]), 64'd1);
      wait_idle();
      bus_read(BASE + 32'h4, rd, ex);
      check("ovf_idle_status", 64'(rd), 64'hC);
      bus_write(BASE + 32'h4, 32'h8, 4'hF);
      bus_read(BASE + 32'h4, rd, ex);
      check("ovf_cleared", 64'(rd), 64'h4);

      // Randomized traffic against the model
      for (int n = 0; n < 80; n++) begin
         int op = $urandom_range(0, 9);
         if (op <= 5) begin
            bus_write(BASE, $urandom, ($urandom_range(0, 1) != 0) ? 4'hF : 4'h1);
         end else if (op <= 7) begin
            bus_read(BASE + 32'h4, rd, ex);
            check("rand_status", 64'(rd), 64'(ex));
         end else if (op == 8) begin
            bus_write(BASE + 32'h4, $urandom, 4'hF);
         end else begin
            a = $urandom;
            if (a[31:4] == BASE[31:4]) a[8] = ~a[8];
            if ($urandom_range(0, 1) != 0) begin
               bus_write(a, $urandom, 4'hF);
            end else begin
               bus_read(a, rd, ex);
               check("rand_unselected", 64'(rd), 64'd0);
            end
         end
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_idle();
      bus_read(BASE + 32'h4, rd, ex);
      check("rand_final_status", 64'(rd), 64'(ex));

      // Reset during DATA bit 3
      k0 = cyc;
      bus_write(BASE, 32'hA5, 4'h1);
      bus_write(BASE, 32'h3C, 4'h1);
      wait_until(k0 + 2 + 17);
      check("rst_pre_bit3", 64'(tx), 64'd0);
      check_en = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      check("rst_tx_high", 64'(tx), 64'd1);
      resetn = 1'b1;
      model_reset();
      @(negedge clk);
      check_en = 1'b1;
      bus_read(BASE + 32'h4, rd, ex);
      check("rst_status", 64'(rd), 64'h4);
      repeat (100) @(negedge clk);
      check("rst_no_tx", 64'(tx), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
